// File: rtl/kf8259_common_pkg.sv
// rtl/kf8259_common_pkg.sv - shared FSM state, OCW2 command codes and control-word bit positions
package kf8259_common_pkg;

    typedef enum logic [1:0] {
        CMD_READY = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } init_state_t;

    // {R, SL, EOI} encodings carried in OCW2 D[7:5]
    localparam logic [2:0] OCW2_CLR_AROT    = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI      = 3'b001;
    localparam logic [2:0] OCW2_NOP         = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI      = 3'b011;
    localparam logic [2:0] OCW2_SET_AROT    = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI  = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO    = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI  = 3'b111;

    localparam int ICW1_IC4     = 0;
    localparam int ICW1_SNGL    = 1;
    localparam int ICW1_LTIM    = 3;
    localparam int ICW2_VEC_LSB = 3;
    localparam int ICW4_MSB     = 4;
    localparam int OCW3_RIS     = 0;
    localparam int OCW3_RR      = 1;
    localparam int OCW3_P       = 2;
    localparam int OCW3_SMM     = 5;
    localparam int OCW3_ESMM    = 6;

endpackage

// File: rtl/kf8259_init_control_if.sv
// rtl/kf8259_init_control_if.sv - strobe/data inputs and configuration outputs of the init sequencer
interface kf8259_init_control_if;

    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;
    logic       read;

    logic       init_busy;
    logic       init_pulse;
    logic [4:0] interrupt_vector_base;
    logic       level_or_edge_triggered;
    logic       single_mode;
    logic [7:0] cascade_config;
    logic [4:0] icw4_config;
    logic [7:0] interrupt_mask;
    logic [2:0] lowest_priority;
    logic       auto_rotate_mode;
    logic       eoi_nonspecific;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic       read_isr_select;
    logic       special_mask_mode;
    logic       poll_pending;

    modport master (
        output internal_data_bus, write_initial_command_word_1, write_initial_command_word_2_4,
               write_operation_control_word_1, write_operation_control_word_2,
               write_operation_control_word_3, read,
        input  init_busy, init_pulse, interrupt_vector_base, level_or_edge_triggered, single_mode,
               cascade_config, icw4_config, interrupt_mask, lowest_priority, auto_rotate_mode,
               eoi_nonspecific, eoi_specific, eoi_rotate, eoi_level, read_isr_select,
               special_mask_mode, poll_pending
    );

    modport slave (
        input  internal_data_bus, write_initial_command_word_1, write_initial_command_word_2_4,
               write_operation_control_word_1, write_operation_control_word_2,
               write_operation_control_word_3, read,
        output init_busy, init_pulse, interrupt_vector_base, level_or_edge_triggered, single_mode,
               cascade_config, icw4_config, interrupt_mask, lowest_priority, auto_rotate_mode,
               eoi_nonspecific, eoi_specific, eoi_rotate, eoi_level, read_isr_select,
               special_mask_mode, poll_pending
    );

endinterface

// File: rtl/kf8259_ocw2_decoder.sv
// rtl/kf8259_ocw2_decoder.sv - combinational OCW2 {R, SL, EOI} command decode
module kf8259_ocw2_decoder
    import kf8259_common_pkg::*;
(
    input  logic [2:0] i_cmd,
    output logic       o_eoi_nonspecific,
    output logic       o_eoi_specific,
    output logic       o_eoi_rotate,
    output logic       o_load_priority,
    output logic       o_set_auto_rotate,
    output logic       o_clear_auto_rotate
);

    always_comb begin
        o_eoi_nonspecific   = 1'b0;
        o_eoi_specific      = 1'b0;
        o_eoi_rotate        = 1'b0;
        o_load_priority     = 1'b0;
        o_set_auto_rotate   = 1'b0;
        o_clear_auto_rotate = 1'b0;
        case (i_cmd)
            OCW2_CLR_AROT:   o_clear_auto_rotate = 1'b1;
            OCW2_NS_EOI:     o_eoi_nonspecific   = 1'b1;
            OCW2_NOP:        ;
            OCW2_SP_EOI:     o_eoi_specific      = 1'b1;
            OCW2_SET_AROT:   o_set_auto_rotate   = 1'b1;
            OCW2_ROT_NS_EOI: begin
                o_eoi_nonspecific = 1'b1;
                o_eoi_rotate      = 1'b1;
            end
            OCW2_SET_PRIO:   o_load_priority     = 1'b1;
            OCW2_ROT_SP_EOI: begin
                o_eoi_specific  = 1'b1;
                o_eoi_rotate    = 1'b1;
                o_load_priority = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/kf8259_init_control.sv
// rtl/kf8259_init_control.sv - ICW1..ICW4 sequencer holding configuration and OCW state
module kf8259_init_control
    import kf8259_common_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    kf8259_init_control_if.slave    bus
);

    init_state_t r_state;
    logic        r_ic4;
    logic        r_read_d;
    logic        r_init_pulse;
    logic [4:0]  r_vector_base;
    logic        r_ltim;
    logic        r_sngl;
    logic [7:0]  r_cascade;
    logic [4:0]  r_icw4;
    logic [7:0]  r_mask;
    logic [2:0]  r_lowest_priority;
    logic        r_auto_rotate;
    logic        r_eoi_nonspecific;
    logic        r_eoi_specific;
    logic        r_eoi_rotate;
    logic [2:0]  r_eoi_level;
    logic        r_read_isr;
    logic        r_smm;
    logic        r_poll;

    logic [7:0]  w_data;
    logic        w_addr1_write;
    logic        w_ocw2_accept;
    logic        w_ocw3_accept;
    logic        w_read_fall;
    logic        w_dec_ns;
    logic        w_dec_sp;
    logic        w_dec_rot;
    logic        w_dec_load;
    logic        w_dec_set_arot;
    logic        w_dec_clr_arot;

    assign w_data        = bus.internal_data_bus;
    // ICW2/3/4 and OCW1 share one A0=1 event; the state decides which it is
    assign w_addr1_write = bus.write_initial_command_word_2_4 | bus.write_operation_control_word_1;
    assign w_ocw2_accept = bus.write_operation_control_word_2 & (r_state == CMD_READY);
    assign w_ocw3_accept = bus.write_operation_control_word_3 & (r_state == CMD_READY);
    assign w_read_fall   = r_read_d & ~bus.read;

    kf8259_ocw2_decoder u_ocw2_decoder (
        .i_cmd               (w_data[7:5]),
        .o_eoi_nonspecific   (w_dec_ns),
        .o_eoi_specific      (w_dec_sp),
        .o_eoi_rotate        (w_dec_rot),
        .o_load_priority     (w_dec_load),
        .o_set_auto_rotate   (w_dec_set_arot),
        .o_clear_auto_rotate (w_dec_clr_arot)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state           <= CMD_READY;
            r_ic4             <= 1'b0;
            r_read_d          <= 1'b0;
            r_init_pulse      <= 1'b0;
            r_vector_base     <= 5'd0;
            r_ltim            <= 1'b0;
            r_sngl            <= 1'b0;
            r_cascade         <= 8'd0;
            r_icw4            <= 5'd0;
            r_mask            <= 8'd0;
            r_lowest_priority <= 3'd7;
            r_auto_rotate     <= 1'b0;
            r_eoi_nonspecific <= 1'b0;
            r_eoi_specific    <= 1'b0;
            r_eoi_rotate      <= 1'b0;
            r_eoi_level       <= 3'd0;
            r_read_isr        <= 1'b0;
            r_smm             <= 1'b0;
            r_poll            <= 1'b0;
        end else begin
            r_init_pulse      <= 1'b0;
            r_eoi_nonspecific <= 1'b0;
            r_eoi_specific    <= 1'b0;
            r_eoi_rotate      <= 1'b0;
            r_read_d          <= bus.read;
            if (w_read_fall) begin
                r_poll <= 1'b0;
            end

            if (bus.write_initial_command_word_1) begin
                r_state           <= WAIT_ICW2;
                r_ltim            <= w_data[ICW1_LTIM];
                r_sngl            <= w_data[ICW1_SNGL];
                r_ic4             <= w_data[ICW1_IC4];
                r_mask            <= 8'd0;
                r_smm             <= 1'b0;
                r_auto_rotate     <= 1'b0;
                r_read_isr        <= 1'b0;
                r_poll            <= 1'b0;
                r_lowest_priority <= 3'd7;
                r_init_pulse      <= 1'b1;
                if (!w_data[ICW1_IC4]) begin
                    r_icw4 <= 5'd0;
                end
            end else if (w_addr1_write) begin
                case (r_state)
                    WAIT_ICW2: begin
                        r_vector_base <= w_data[7:ICW2_VEC_LSB];
                        if (!r_sngl)
                            r_state <= WAIT_ICW3;
                        else if (r_ic4)
                            r_state <= WAIT_ICW4;
                        else
                            r_state <= CMD_READY;
                    end
                    WAIT_ICW3: begin
                        r_cascade <= w_data;
                        r_state   <= r_ic4 ? WAIT_ICW4 : CMD_READY;
                    end
                    WAIT_ICW4: begin
                        r_icw4  <= w_data[ICW4_MSB:0];
                        r_state <= CMD_READY;
                    end
                    default: r_mask <= w_data;
                endcase
            end else if (w_ocw2_accept) begin
                r_eoi_nonspecific <= w_dec_ns;
                r_eoi_specific    <= w_dec_sp;
                r_eoi_rotate      <= w_dec_rot;
                r_eoi_level       <= w_data[2:0];
                if (w_dec_load)
                    r_lowest_priority <= w_data[2:0];
                if (w_dec_set_arot)
                    r_auto_rotate <= 1'b1;
                else if (w_dec_clr_arot)
                    r_auto_rotate <= 1'b0;
            end else if (w_ocw3_accept) begin
                if (w_data[OCW3_RR])
                    r_read_isr <= w_data[OCW3_RIS];
                if (w_data[OCW3_ESMM])
                    r_smm <= w_data[OCW3_SMM];
                if (w_data[OCW3_P])
                    r_poll <= 1'b1;
            end
        end
    end

    assign bus.init_busy               = (r_state != CMD_READY);
    assign bus.init_pulse              = r_init_pulse;
    assign bus.interrupt_vector_base   = r_vector_base;
    assign bus.level_or_edge_triggered = r_ltim;
    assign bus.single_mode             = r_sngl;
    assign bus.cascade_config          = r_cascade;
    assign bus.icw4_config             = r_icw4;
    assign bus.interrupt_mask          = r_mask;
    assign bus.lowest_priority         = r_lowest_priority;
    assign bus.auto_rotate_mode        = r_auto_rotate;
    assign bus.eoi_nonspecific         = r_eoi_nonspecific;
    assign bus.eoi_specific            = r_eoi_specific;
    assign bus.eoi_rotate              = r_eoi_rotate;
    assign bus.eoi_level               = r_eoi_level;
    assign bus.read_isr_select         = r_read_isr;
    assign bus.special_mask_mode       = r_smm;
    assign bus.poll_pending            = r_poll;

endmodule

// File: tb/tb_kf8259_init_control.sv
// tb/tb_kf8259_init_control.sv - directed and randomized checks against a queue-based reference model
module tb_kf8259_init_control;

    localparam int K_IDLE = 0;
    localparam int K_ICW1 = 1;
    localparam int K_A0   = 2;
    localparam int K_OCW2 = 3;
    localparam int K_OCW3 = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    kf8259_init_control_if bus ();

    kf8259_init_control dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: outstanding ICWs are a queue of names
    string      pend[$];
    logic [4:0] m_vec;
    logic       m_ltim, m_sngl;
    logic [7:0] m_casc;
    logic [4:0] m_icw4;
    logic [7:0] m_mask;
    logic [2:0] m_lp;
    logic       m_arot, m_ris, m_smm, m_poll;
    logic       m_ns, m_sp, m_rot, m_ipulse;
    logic [2:0] m_lvl;
    logic       m_prev_read;
    logic       cur_read;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_vec = 0; m_ltim = 0; m_sngl = 0; m_casc = 0; m_icw4 = 0; m_mask = 0;
        m_lp = 3'd7; m_arot = 0; m_ris = 0; m_smm = 0; m_poll = 0;
        m_ns = 0; m_sp = 0; m_rot = 0; m_ipulse = 0; m_lvl = 0; m_prev_read = 0;
    endtask

    task automatic model_step(input int kind, input logic [7:0] d, input logic rd);
        string nxt;
        m_ns = 0; m_sp = 0; m_rot = 0; m_ipulse = 0;
        if (m_prev_read && !rd) m_poll = 0;
        m_prev_read = rd;
        case (kind)
            K_ICW1: begin
                pend.delete();
                pend.push_back("ICW2");
                if (!d[1]) pend.push_back("ICW3");
                if (d[0])  pend.push_back("ICW4");
                m_ltim = d[3]; m_sngl = d[1];
                m_mask = 0; m_smm = 0; m_arot = 0; m_ris = 0; m_poll = 0; m_lp = 7;
                if (!d[0]) m_icw4 = 0;
                m_ipulse = 1;
            end
            K_A0: begin
                if (pend.size() == 0) m_mask = d;
                else begin
                    nxt = pend.pop_front();
                    if (nxt == "ICW2")      m_vec  = d[7:3];
                    else if (nxt == "ICW3") m_casc = d;
                    else                    m_icw4 = d[4:0];
                end
            end
            K_OCW2: if (pend.size() == 0) begin
                m_lvl = d[2:0];
                case (d[7:5])
                    3'b001: m_ns = 1;
                    3'b011: m_sp = 1;
                    3'b101: begin m_ns = 1; m_rot = 1; end
                    3'b111: begin m_sp = 1; m_rot = 1; m_lp = d[2:0]; end
                    3'b110: m_lp = d[2:0];
                    3'b100: m_arot = 1;
                    3'b000: m_arot = 0;
                    default: ;
                endcase
            end
            K_OCW3: if (pend.size() == 0) begin
                if (d[1]) m_ris = d[0];
                if (d[6]) m_smm = d[5];
                if (d[2]) m_poll = 1;
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("init_busy",   bus.init_busy,               pend.size() != 0);
        chk("init_pulse",  bus.init_pulse,              m_ipulse);
        chk("vector_base", bus.interrupt_vector_base,   m_vec);
        chk("ltim",        bus.level_or_edge_triggered, m_ltim);
        chk("single_mode", bus.single_mode,             m_sngl);
        chk("cascade",     bus.cascade_config,          m_casc);
        chk("icw4",        bus.icw4_config,             m_icw4);
        chk("mask",        bus.interrupt_mask,          m_mask);
        chk("lowest_prio", bus.lowest_priority,         m_lp);
        chk("auto_rotate", bus.auto_rotate_mode,        m_arot);
        chk("eoi_ns",      bus.eoi_nonspecific,         m_ns);
        chk("eoi_sp",      bus.eoi_specific,            m_sp);
        chk("eoi_rot",     bus.eoi_rotate,              m_rot);
        chk("eoi_level",   bus.eoi_level,               m_lvl);
        chk("read_isr",    bus.read_isr_select,         m_ris);
        chk("smm",         bus.special_mask_mode,       m_smm);
        chk("poll",        bus.poll_pending,            m_poll);
    endtask

    // Drive one clock of stimulus, then compare every output against the model
    task automatic apply(input int kind, input logic [7:0] d, input logic rst);
        bus.internal_data_bus              = d;
        bus.write_initial_command_word_1   = (kind == K_ICW1);
        bus.write_initial_command_word_2_4 = (kind == K_A0);
        bus.write_operation_control_word_1 = (kind == K_A0);
        bus.write_operation_control_word_2 = (kind == K_OCW2);
        bus.write_operation_control_word_3 = (kind == K_OCW3);
        bus.read                           = cur_read;
        reset_n                            = !rst;
        @(posedge clock);
        #1;
        bus.write_initial_command_word_1   = 1'b0;
        bus.write_initial_command_word_2_4 = 1'b0;
        bus.write_operation_control_word_1 = 1'b0;
        bus.write_operation_control_word_2 = 1'b0;
        bus.write_operation_control_word_3 = 1'b0;
        reset_n                            = 1'b1;
        if (rst) model_reset();
        else     model_step(kind, d, cur_read);
        check_all();
    endtask

    initial begin
        int         r;
        int         kind;
        logic [7:0] d;
        logic       rst;

        cur_read = 1'b0;
        model_reset();
        apply(K_IDLE, 8'h00, 1'b1);
        chk("reset_lp7", bus.lowest_priority, 3'd7);
        chk("reset_mask", bus.interrupt_mask, 8'h00);

        // Single mode with ICW4: WAIT_ICW3 skipped
        apply(K_ICW1, 8'h13, 1'b0);
        chk("icw1_pulse", bus.init_pulse, 1'b1);
        apply(K_A0, 8'h20, 1'b0);
        chk("busy_after_icw2", bus.init_busy, 1'b1);
        apply(K_A0, 8'h01, 1'b0);
        chk("busy_after_icw4", bus.init_busy, 1'b0);
        chk("vec_04", bus.interrupt_vector_base, 5'h04);
        chk("icw4_01", bus.icw4_config, 5'h01);

        // Cascade sequence then OCW1
        apply(K_ICW1, 8'h11, 1'b0);
        apply(K_A0, 8'h08, 1'b0);
        apply(K_A0, 8'h04, 1'b0);
        apply(K_A0, 8'h03, 1'b0);
        chk("cascade_04", bus.cascade_config, 8'h04);
        chk("icw4_03", bus.icw4_config, 5'h03);
        apply(K_A0, 8'hFB, 1'b0);
        chk("mask_fb", bus.interrupt_mask, 8'hFB);

        // Restart from WAIT_ICW3
        apply(K_ICW1, 8'h11, 1'b0);
        apply(K_A0, 8'h08, 1'b0);
        apply(K_ICW1, 8'h12, 1'b0);
        chk("restart_pulse", bus.init_pulse, 1'b1);
        chk("restart_mask", bus.interrupt_mask, 8'h00);
        chk("restart_icw4", bus.icw4_config, 5'h00);
        apply(K_A0, 8'h40, 1'b0);
        chk("restart_done", bus.init_busy, 1'b0);

        // OCW2 / OCW3
        apply(K_OCW2, 8'hE5, 1'b0);
        chk("e5_sp", bus.eoi_specific, 1'b1);
        chk("e5_lp", bus.lowest_priority, 3'd5);
        apply(K_IDLE, 8'h00, 1'b0);
        chk("e5_pulse_end", bus.eoi_rotate, 1'b0);
        chk("e5_level_hold", bus.eoi_level, 3'd5);
        apply(K_OCW2, 8'h80, 1'b0);
        chk("arot_set", bus.auto_rotate_mode, 1'b1);
        apply(K_OCW3, 8'h0B, 1'b0);
        apply(K_OCW3, 8'h68, 1'b0);
        apply(K_OCW3, 8'h0C, 1'b0);
        chk("poll_set", bus.poll_pending, 1'b1);
        cur_read = 1'b1;
        apply(K_IDLE, 8'h00, 1'b0);
        apply(K_IDLE, 8'h00, 1'b0);
        chk("poll_held", bus.poll_pending, 1'b1);
        cur_read = 1'b0;
        apply(K_IDLE, 8'h00, 1'b0);
        chk("poll_cleared", bus.poll_pending, 1'b0);

        // Reset dominates a coincident OCW1
        apply(K_OCW2, 8'hC2, 1'b0);
        apply(K_A0, 8'hAA, 1'b1);
        chk("rst_mask", bus.interrupt_mask, 8'h00);
        chk("rst_lp", bus.lowest_priority, 3'd7);
        chk("rst_busy", bus.init_busy, 1'b0);

        for (int i = 0; i < 600; i++) begin
            r   = $urandom_range(0, 99);
            d   = 8'($urandom);
            rst = 1'b0;
            if (r < 3) begin
                kind = K_IDLE;
                rst  = 1'b1;
            end else if (pend.size() != 0) begin
                if (r < 80)      kind = K_A0;
                else if (r < 88) kind = K_ICW1;
                else if (r < 94) kind = K_OCW2;
                else             kind = K_OCW3;
            end else begin
                if (r < 10)      kind = K_ICW1;
                else if (r < 30) kind = K_A0;
                else if (r < 55) kind = K_OCW2;
                else if (r < 80) kind = K_OCW3;
                else             kind = K_IDLE;
            end
            if (kind == K_ICW1) d[4] = 1'b1;
            if (kind == K_OCW2) d[4:3] = 2'b00;
            if (kind == K_OCW3) begin d[4] = 1'b0; d[3] = 1'b1; end
            if (kind == K_IDLE && !rst && $urandom_range(0, 1) == 1) cur_read = ~cur_read;
            if (rst) cur_read = 1'b0;
            apply(kind, d, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/kf8259_init_control.md
# kf8259_init_control

Initialization and operation-command sequencer for the KF8259 interrupt controller. It sits directly downstream of the bus control logic and consumes its one-cycle write strobes and the latched internal data bus. It walks the ICW1→ICW2→ICW3→ICW4 sequence, holds all configuration and OCW state registers, and emits decoded command pulses to the priority/in-service logic.

## Interface
- Parameters: none. All widths are fixed by the 8259A architecture.
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- internal_data_bus  in  8  latched write data from bus control
- write_initial_command_word_1  in  1  ICW1 strobe (A0=0, D4=1)
- write_initial_command_word_2_4  in  1  A0=1 write strobe
- write_operation_control_word_1  in  1  A0=1 write strobe (same event as above)
- write_operation_control_word_2  in  1  OCW2 strobe (A0=0, D4=0, D3=0)
- write_operation_control_word_3  in  1  OCW3 strobe (A0=0, D4=0, D3=1)
- read  in  1  CPU read active, level
- init_busy  out  1  high while the ICW sequence is incomplete
- init_pulse  out  1  one cycle after ICW1 accept; downstream clears IRR edge state and ISR
- interrupt_vector_base  out  5  ICW2[7:3]
- level_or_edge_triggered  out  1  ICW1 LTIM (1 = level)
- single_mode  out  1  ICW1 SNGL
- cascade_config  out  8  ICW3 raw (slave bitmap for master, ID in [2:0] for slave)
- icw4_config  out  5  {SFNM, BUF, M/S, AEOI, uPM}
- interrupt_mask  out  8  OCW1 mask register
- lowest_priority  out  3  IR level with lowest priority
- auto_rotate_mode  out  1  rotate-in-AEOI flag
- eoi_nonspecific / eoi_specific / eoi_rotate  out  1 each  one-cycle command pulses
- eoi_level  out  3  OCW2 L2..L0, valid with the pulses
- read_isr_select  out  1  0 = IRR, 1 = ISR on status read
- special_mask_mode  out  1  SMM flag
- poll_pending  out  1  poll command armed

## Operation
- FSM states: CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4. `init_busy` = (state != CMD_READY).
- ICW1 in any state:
  - Go to WAIT_ICW2.
  - Latch LTIM, SNGL, and IC4.
  - Clear interrupt_mask to 0x00, special_mask_mode, auto_rotate_mode, read_isr_select, and poll_pending.
  - Set lowest_priority to 7.
  - If IC4=0, clear icw4_config to 0.
  - Pulse init_pulse.
- Address-1 write in WAIT_ICW2: latch vector base from D[7:3]. Next state is WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else CMD_READY.
- Address-1 write in WAIT_ICW3: latch cascade_config. Next state is WAIT_ICW4 if IC4=1, else CMD_READY.
- Address-1 write in WAIT_ICW4: latch icw4_config from D[4:0]. Next state is CMD_READY.
- Address-1 write in CMD_READY: OCW1, so interrupt_mask <= bus. Address-1 writes in any other state never touch interrupt_mask.
- OCW2 and OCW3 strobes are ignored while init_busy=1.
- OCW2 decode on {R, SL, EOI} = D[7:5]:
  - 001: eoi_nonspecific.
  - 011: eoi_specific.
  - 101: eoi_nonspecific + eoi_rotate.
  - 111: eoi_specific + eoi_rotate, and lowest_priority <= L.
  - 110: lowest_priority <= L.
  - 100: set auto_rotate_mode.
  - 000: clear auto_rotate_mode.
  - 010: no-op.
- OCW3:
  - If RR=1, read_isr_select <= RIS.
  - If ESMM=1, special_mask_mode <= SMM.
  - If P=1, set poll_pending.
- poll_pending clears on the cycle after read falls from 1 to 0. This needs one registered copy of read.

## Timing
- All outputs are registered. Register updates and pulses appear exactly one clock after the sampled strobe.
- Pulses are one clock wide.
- Strobes are one clock wide and are sampled on posedge.
- eoi_level stays valid for the pulse cycle and holds until the next OCW2.
- Reset values:
  - State CMD_READY.
  - lowest_priority = 7.
  - All other outputs 0, including interrupt_mask = 0x00 and all pulses.
- reset_n low dominates any simultaneous strobe. Reset mid-sequence returns to CMD_READY with no partial ICW retained.
- An ICW1 arriving in WAIT_ICW3 or WAIT_ICW4 restarts the sequence; earlier ICW2/3 values are overwritten by the new sequence.
- Simultaneous ICW2_4 and OCW1 strobes are one event; the FSM state alone selects the interpretation.

## Structure
- Shared package `kf8259_common_pkg` holds:
  - the FSM state enum;
  - OCW2 command encodings (3-bit localparams);
  - ICW1/ICW4/OCW3 bit-index constants.
- One sub-module, `kf8259_ocw2_decoder`: combinational {R, SL, EOI} to pulse-enable and priority-load decode, registered in the parent.

## Test plan
- ICW1=0x13, ICW2=0x20, ICW4=0x01 → init_busy drops after ICW4; vector base 0x04; single_mode=1; icw4_config=0x01; WAIT_ICW3 skipped.
- ICW1=0x11, ICW2=0x08, ICW3=0x04, ICW4=0x03 → cascade_config=0x04; icw4_config=0x03. A following A0=1 write of 0xFB → interrupt_mask=0xFB.
- Mid-sequence ICW1=0x12 in WAIT_ICW3 → state WAIT_ICW2, init_pulse fires, mask 0x00, icw4_config 0.
- OCW2=0xE5 → eoi_specific and eoi_rotate pulse one cycle, eoi_level=5, lowest_priority=5. OCW2=0x80 → auto_rotate_mode=1.
- OCW3=0x0B → read_isr_select=1. OCW3=0x68 → special_mask_mode=1. OCW3=0x0C → poll_pending=1, cleared the cycle after read returns low.
- reset_n low coincident with an OCW1 write → mask 0x00, lowest_priority 7, state CMD_READY.
